// File: rtl/eth_vlg_pkg.sv
// Ethernet-layer shared types and constants.
package eth_vlg_pkg;

    localparam logic [47:0] ETH_BCAST = 48'hFFFF_FFFF_FFFF;

    localparam int unsigned RX_LEN_W = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } rx_demux_state_t;

endpackage

// File: rtl/mac_vlg_pkg.sv
// MAC-level shared constants.
package mac_vlg_pkg;

    localparam logic [15:0] ETYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETYPE_IPV4 = 16'h0800;

endpackage

// File: rtl/eth_vlg_sat_cnt.sv
// Saturating counter; adds inc (0..3) each cycle and sticks at all-ones.
module eth_vlg_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   inc,
    output logic [W-1:0] cnt
);

    localparam int unsigned SW = W + 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W:0]   sum;

    // Widened add so overflow is visible as the carry bit.
    always_comb begin
        sum   = {1'b0, cnt_q} + SW'(inc);
        cnt_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/eth_vlg_rx_demux.sv
// RX frame dispatcher: MAC filter, EtherType routing, length/error flagging, stats.
module eth_vlg_rx_demux
    import eth_vlg_pkg::*;
    import mac_vlg_pkg::*;
#(
    parameter int unsigned        N       = 2,
    parameter logic [0:N-1][15:0] ETYPES  = {ETYPE_ARP, ETYPE_IPV4},
    parameter int unsigned        MAX_LEN = 1500,
    parameter int unsigned        MIN_LEN = 46,
    parameter int unsigned        CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [47:0]               dev_mac,
    input  logic [7:0]                in_dat,
    input  logic                      in_val,
    input  logic                      in_sof,
    input  logic                      in_eof,
    input  logic                      in_err,
    input  logic [47:0]               in_dst,
    input  logic [15:0]               in_etype,
    output logic [7:0]                out_dat,
    output logic [N-1:0]              out_val,
    output logic [N-1:0]              out_sof,
    output logic [N-1:0]              out_eof,
    output logic [N-1:0]              out_err,
    output logic [N-1:0][CNT_W-1:0]   cnt_fwd,
    output logic [CNT_W-1:0]          cnt_drop
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [RX_LEN_W-1:0] MAX_L = RX_LEN_W'(MAX_LEN);
    localparam logic [RX_LEN_W-1:0] MIN_L = RX_LEN_W'(MIN_LEN);

    rx_demux_state_t     state_q, state_d;
    logic [PW-1:0]       port_q, port_d;
    logic [RX_LEN_W-1:0] len_q, len_d;
    logic [7:0]          out_dat_q, out_dat_d;
    logic [N-1:0]        out_val_q, out_val_d;
    logic [N-1:0]        out_sof_q, out_sof_d;
    logic [N-1:0]        out_eof_q, out_eof_d;
    logic [N-1:0]        out_err_q, out_err_d;
    logic [N-1:0][1:0]   inc_fwd;
    logic [1:0]          inc_drop;

    logic                sof_v, eof_v, mac_ok, hit, accept, frame_err;
    logic [PW-1:0]       hit_port;
    logic [RX_LEN_W-1:0] len_inc, len_now;

    // Header decode: address filter, lowest-index EtherType match, running length.
    always_comb begin
        sof_v    = in_val & in_sof;
        eof_v    = in_val & in_eof;
        mac_ok   = (in_dst == dev_mac) | (in_dst == ETH_BCAST);
        hit      = 1'b0;
        hit_port = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_etype == ETYPES[i]) begin
                hit      = 1'b1;
                hit_port = PW'(i);
            end
        end
        accept    = mac_ok & hit;
        len_inc   = (len_q == {RX_LEN_W{1'b1}}) ? len_q : len_q + RX_LEN_W'(1);
        len_now   = (state_q == FWD) ? len_inc : RX_LEN_W'(1);
        frame_err = in_err | (len_now > MAX_L) | (len_now < MIN_L);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state plus latched port and length.
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        len_d   = len_q;
        case (state_q)
            IDLE, DROP: begin
                if (sof_v) begin
                    if (accept) begin
                        port_d  = hit_port;
                        len_d   = RX_LEN_W'(1);
                        state_d = eof_v ? IDLE : FWD;
                    end else begin
                        state_d = eof_v ? IDLE : DROP;
                    end
                end else if (eof_v) begin
                    state_d = IDLE;
                end
            end
            FWD: begin
                if (sof_v) begin
                    state_d = eof_v ? IDLE : DROP;
                end else if (in_val) begin
                    len_d = len_inc;
                    if (in_eof) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output strobes and counter increments.
    always_comb begin
        out_dat_d = out_dat_q;
        out_val_d = '0;
        out_sof_d = '0;
        out_eof_d = '0;
        out_err_d = '0;
        inc_fwd   = '0;
        inc_drop  = 2'd0;
        case (state_q)
            IDLE, DROP: begin
                if (sof_v) begin
                    if (accept) begin
                        out_dat_d           = in_dat;
                        out_val_d[hit_port] = 1'b1;
                        out_sof_d[hit_port] = 1'b1;
                        if (in_eof) begin
                            out_eof_d[hit_port] = 1'b1;
                            out_err_d[hit_port] = frame_err;
                            if (frame_err) inc_drop          = 2'd1;
                            else           inc_fwd[hit_port] = 2'd1;
                        end
                    end else begin
                        inc_drop = 2'd1;
                    end
                end
            end
            FWD: begin
                if (sof_v) begin
                    // Missing eof: close the open frame and drop the new one.
                    out_eof_d[port_q] = 1'b1;
                    out_err_d[port_q] = 1'b1;
                    inc_drop          = 2'd2;
                end else if (in_val) begin
                    out_dat_d         = in_dat;
                    out_val_d[port_q] = 1'b1;
                    if (in_eof) begin
                        out_eof_d[port_q] = 1'b1;
                        out_err_d[port_q] = frame_err;
                        if (frame_err) inc_drop        = 2'd1;
                        else           inc_fwd[port_q] = 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_q    <= '0;
            len_q     <= '0;
            out_dat_q <= '0;
            out_val_q <= '0;
            out_sof_q <= '0;
            out_eof_q <= '0;
            out_err_q <= '0;
        end else begin
            port_q    <= port_d;
            len_q     <= len_d;
            out_dat_q <= out_dat_d;
            out_val_q <= out_val_d;
            out_sof_q <= out_sof_d;
            out_eof_q <= out_eof_d;
            out_err_q <= out_err_d;
        end
    end

    assign out_dat = out_dat_q;
    assign out_val = out_val_q;
    assign out_sof = out_sof_q;
    assign out_eof = out_eof_q;
    assign out_err = out_err_q;

    for (genvar g = 0; g < N; g++) begin : g_fwd_cnt
        eth_vlg_sat_cnt #(.W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc_fwd[g]),
            .cnt (cnt_fwd[g])
        );
    end

    eth_vlg_sat_cnt #(.W(CNT_W)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_drop),
        .cnt (cnt_drop)
    );

endmodule

// File: tb/tb_eth_vlg_rx_demux.sv
// Self-checking bench for eth_vlg_rx_demux against a frame-level reference model.
module tb_eth_vlg_rx_demux;

    localparam int N  = 2;
    localparam int CW = 16;
    localparam logic [47:0] DEV   = 48'h02_11_22_33_44_55;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_01;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         in_dat = '0;
    logic               in_val = 1'b0, in_sof = 1'b0, in_eof = 1'b0, in_err = 1'b0;
    logic [47:0]        in_dst = '0;
    logic [15:0]        in_etype = '0;
    logic [7:0]         out_dat;
    logic [N-1:0]       out_val, out_sof, out_eof, out_err;
    logic [N-1:0][CW-1:0] cnt_fwd;
    logic [CW-1:0]      cnt_drop;

    eth_vlg_rx_demux dut (
        .clk(clk), .rst(rst), .dev_mac(DEV),
        .in_dat(in_dat), .in_val(in_val), .in_sof(in_sof), .in_eof(in_eof),
        .in_err(in_err), .in_dst(in_dst), .in_etype(in_etype),
        .out_dat(out_dat), .out_val(out_val), .out_sof(out_sof),
        .out_eof(out_eof), .out_err(out_err),
        .cnt_fwd(cnt_fwd), .cnt_drop(cnt_drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame in progress (0 none, 1 delivering, 2 discarding).
    logic [15:0]  tb_etypes [N] = '{16'h0806, 16'h0800};
    int           mode, cur_port, cur_len;
    int           exp_fwd [N];
    int           exp_drop;
    logic [N-1:0] e_val, e_sof, e_eof, e_err;
    logic [7:0]   e_dat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int bump(input int v, input int by);
        return (v + by > 65535) ? 65535 : v + by;
    endfunction

    function automatic int lookup(input logic [47:0] dst, input logic [15:0] et);
        if (dst != DEV && dst != BCAST) return -1;
        for (int i = 0; i < N; i++) if (et == tb_etypes[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        mode = 0; cur_port = 0; cur_len = 0;
        for (int i = 0; i < N; i++) exp_fwd[i] = 0;
        exp_drop = 0;
        e_val = '0; e_sof = '0; e_eof = '0; e_err = '0; e_dat = '0;
    endtask

    task automatic model_finish(input bit err);
        bit bad;
        bad = err || cur_len > 1500 || cur_len < 46;
        e_eof[cur_port] = 1'b1;
        e_err[cur_port] = bad;
        if (bad) exp_drop = bump(exp_drop, 1);
        else     exp_fwd[cur_port] = bump(exp_fwd[cur_port], 1);
        mode = 0;
    endtask

    task automatic model_step(input bit v, input bit s, input bit e, input bit er,
                              input logic [7:0] d, input logic [47:0] dst, input logic [15:0] et);
        int p;
        e_val = '0; e_sof = '0; e_eof = '0; e_err = '0;
        if (!v) return;
        if (s) begin
            if (mode == 1) begin
                e_eof[cur_port] = 1'b1;
                e_err[cur_port] = 1'b1;
                exp_drop = bump(exp_drop, 2);
                mode = e ? 0 : 2;
            end else begin
                p = lookup(dst, et);
                if (p >= 0) begin
                    cur_port = p; cur_len = 1; mode = 1;
                    e_val[p] = 1'b1; e_sof[p] = 1'b1; e_dat = d;
                    if (e) model_finish(er);
                end else begin
                    exp_drop = bump(exp_drop, 1);
                    mode = e ? 0 : 2;
                end
            end
        end else if (mode == 1) begin
            cur_len++;
            e_val[cur_port] = 1'b1; e_dat = d;
            if (e) model_finish(er);
        end else if (mode == 2 && e) begin
            mode = 0;
        end
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_val"}, 64'(out_val), 64'(e_val));
        check({pfx, "_sof"}, 64'(out_sof), 64'(e_sof));
        check({pfx, "_eof"}, 64'(out_eof), 64'(e_eof));
        check({pfx, "_err"}, 64'(out_err), 64'(e_err));
        if (e_val != '0) check({pfx, "_dat"}, 64'(out_dat), 64'(e_dat));
        for (int i = 0; i < N; i++) check($sformatf("%s_fwd%0d", pfx, i), 64'(cnt_fwd[i]), 64'(exp_fwd[i]));
        check({pfx, "_drop"}, 64'(cnt_drop), 64'(exp_drop));
    endtask

    // Drive one cycle (called at posedge+1), then check just after the next edge.
    task automatic drive_cycle(input bit v, input bit s, input bit e, input bit er,
                               input logic [7:0] d, input logic [47:0] dst, input logic [15:0] et);
        in_val = v; in_sof = s; in_eof = e; in_err = er;
        in_dat = d; in_dst = dst; in_etype = et;
        model_step(v, s, e, er, d, dst, et);
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    task automatic gap_cycle();
        drive_cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
                    {16'($urandom), 32'($urandom)}, 16'($urandom));
    endtask

    task automatic async_reset();
        in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // gap_mode: 0 none, 1 random, 2 every third cycle.
    task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int len,
                              input bit err, input int gap_mode, input int resof_at, input int rst_at);
        bit s, e;
        logic [47:0] hd;
        logic [15:0] he;
        for (int i = 0; i < len; i++) begin
            if (i == rst_at) async_reset();
            if ((gap_mode == 1 && $urandom_range(0, 3) == 0) || (gap_mode == 2 && i % 3 == 2))
                gap_cycle();
            s  = (i == 0) || (i == resof_at);
            e  = (i == len - 1);
            hd = s ? dst : {16'($urandom), 32'($urandom)};
            he = s ? et  : 16'($urandom);
            drive_cycle(1'b1, s, e, e ? err : 1'($urandom), 8'($urandom), hd, he);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 48'h0, 16'h0);
    endtask

    int lens [10] = '{1, 28, 45, 46, 47, 60, 1500, 1501, 2100, 0};

    initial begin
        logic [47:0] dst;
        logic [15:0] et;
        int len, resof, pick;

        model_reset();
        #1;
        check_outputs("reset0");
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset1");
        rst = 1'b0;

        send_frame(DEV, 16'h0800, 60, 1'b0, 0, -1, -1);
        check("tp1_fwd1", 64'(cnt_fwd[1]), 64'd1);
        check("tp1_drop", 64'(cnt_drop), 64'd0);

        send_frame(BCAST, 16'h0806, 28, 1'b0, 1, -1, -1);
        check("tp2_drop", 64'(cnt_drop), 64'd1);
        check("tp2_fwd0", 64'(cnt_fwd[0]), 64'd0);

        send_frame(OTHER, 16'h0800, 40, 1'b0, 0, -1, -1);
        send_frame(DEV, 16'h86DD, 40, 1'b0, 1, -1, -1);
        check("tp3_drop", 64'(cnt_drop), 64'd3);

        send_frame(DEV, 16'h0800, 1501, 1'b0, 0, -1, -1);
        send_frame(DEV, 16'h0800, 100, 1'b1, 1, -1, -1);
        check("tp4_drop", 64'(cnt_drop), 64'd5);
        check("tp4_fwd1", 64'(cnt_fwd[1]), 64'd1);

        send_frame(DEV, 16'h0800, 100, 1'b0, 0, 50, -1);
        check("tp5_drop", 64'(cnt_drop), 64'd7);
        send_frame(DEV, 16'h0800, 60, 1'b0, 0, -1, -1);
        check("tp5_fwd1", 64'(cnt_fwd[1]), 64'd2);

        send_frame(DEV, 16'h0800, 200, 1'b0, 2, -1, 30);
        check("tp6_drop", 64'(cnt_drop), 64'd0);
        check("tp6_fwd1", 64'(cnt_fwd[1]), 64'd0);
        send_frame(DEV, 16'h0800, 64, 1'b0, 0, -1, -1);
        check("tp6_fwd1b", 64'(cnt_fwd[1]), 64'd1);

        for (int f = 0; f < 30; f++) begin
            pick = $urandom_range(0, 3);
            dst  = (pick == 0) ? OTHER : (pick == 1) ? BCAST : DEV;
            pick = $urandom_range(0, 4);
            et   = (pick == 0) ? 16'h86DD : (pick < 3) ? 16'h0806 : 16'h0800;
            len  = lens[$urandom_range(0, 9)];
            if (len == 0 || (len > 1000 && $urandom_range(0, 2) != 0)) len = $urandom_range(1, 300);
            resof = (len > 4 && $urandom_range(0, 7) == 0) ? $urandom_range(1, len - 1) : -1;
            for (int k = $urandom_range(0, 2); k > 0; k--)
                drive_cycle(1'b1, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom), DEV, 16'h0800);
            send_frame(dst, et, len, ($urandom_range(0, 4) == 0), $urandom_range(0, 2), resof, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
